// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator. The envelope advances on sample ticks.
// Gate and trigger events are evaluated on every clock.
module adsr_envelope #(
  parameter int ENV_WIDTH  = 16,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sample_tick_in,
  input  logic                  gate_in,
  input  logic                  trigger_in,
  input  logic [RATE_WIDTH-1:0] attack_step_in,
  input  logic [RATE_WIDTH-1:0] decay_step_in,
  input  logic [RATE_WIDTH-1:0] release_step_in,
  input  logic [ENV_WIDTH-1:0]  sustain_in,
  output logic [ENV_WIDTH-1:0]  env_out,
  output logic [2:0]            stage_out,
  output logic                  active_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int                 PAD     = ENV_WIDTH + 1 - RATE_WIDTH;
  localparam logic [ENV_WIDTH:0] MAX_EXT = {1'b0, {ENV_WIDTH{1'b1}}};

  state_t               state_q, state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d;
  logic                 active_q;

  // All arithmetic is one bit wider than the envelope so that neither
  // overflow nor underflow can wrap.
  logic        [ENV_WIDTH:0] env_ext, sus_ext, atk_ext, dec_ext, rel_ext;
  logic        [ENV_WIDTH:0] atk_sum;
  logic signed [ENV_WIDTH:0] dec_diff;

  assign env_ext  = {1'b0, env_q};
  assign sus_ext  = {1'b0, sustain_in};
  assign atk_ext  = {{PAD{1'b0}}, attack_step_in};
  assign dec_ext  = {{PAD{1'b0}}, decay_step_in};
  assign rel_ext  = {{PAD{1'b0}}, release_step_in};
  assign atk_sum  = env_ext + atk_ext;
  assign dec_diff = $signed(env_ext - dec_ext);

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (trigger_in && gate_in) begin
      // Retrigger keeps the current level so there is no click.
      state_d = ATTACK;
    end else if (!gate_in && (state_q == ATTACK || state_q == DECAY ||
                              state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (sample_tick_in) begin
      case (state_q)
        IDLE: env_d = '0;
        ATTACK: begin
          if (attack_step_in == '0 || atk_sum >= MAX_EXT) begin
            env_d   = '1;
            state_d = DECAY;
          end else begin
            env_d = atk_sum[ENV_WIDTH-1:0];
          end
        end
        DECAY: begin
          if (decay_step_in == '0 || dec_diff <= $signed(sus_ext)) begin
            env_d   = sustain_in;
            state_d = SUSTAIN;
          end else begin
            env_d = dec_diff[ENV_WIDTH-1:0];
          end
        end
        SUSTAIN: env_d = sustain_in;
        RELEASE: begin
          if (release_step_in == '0 || env_ext <= rel_ext) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = env_q - rel_ext[ENV_WIDTH-1:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      env_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      active_q <= (state_d != IDLE);
    end
  end

  assign env_out    = env_q;
  assign stage_out  = state_q;
  assign active_out = active_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: ramps, boundaries, retrigger and async reset.
module tb_adsr_envelope;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        gate = 1'b0;
  logic        trig = 1'b0;
  logic [7:0]  atk = 8'h00;
  logic [7:0]  dec = 8'h00;
  logic [7:0]  rel = 8'h00;
  logic [15:0] sus = 16'h0000;
  logic [15:0] env;
  logic [2:0]  stage;
  logic        active;

  int n_checks = 0;
  int n_pass   = 0;

  adsr_envelope #(.ENV_WIDTH(16), .RATE_WIDTH(8)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sample_tick_in  (tick),
    .gate_in         (gate),
    .trigger_in      (trig),
    .attack_step_in  (atk),
    .decay_step_in   (dec),
    .release_step_in (rel),
    .sustain_in      (sus),
    .env_out         (env),
    .stage_out       (stage),
    .active_out      (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic state_chk(input string tag, input logic [15:0] e_env,
                           input logic [2:0] e_stage, input logic e_act);
    chk({tag, "_env"}, {16'h0, env}, {16'h0, e_env});
    chk({tag, "_stage"}, {29'h0, stage}, {29'h0, e_stage});
    chk({tag, "_active"}, {31'h0, active}, {31'h0, e_act});
  endtask

  // One clock: inputs set at a falling edge are sampled at the next rising
  // edge, outputs are read at the falling edge after it.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One sample period of four clocks, tick high in the first.
  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    @(negedge clk);
    cyc();
    state_chk("reset", 16'h0000, 3'd0, 1'b0);
    rst = 1'b0;
    cyc();

    // Trigger without gate, and gate without trigger, both stay idle.
    trig = 1'b1; tick = 1'b1;
    cyc();
    trig = 1'b0; tick = 1'b0;
    state_chk("trig_nogate", 16'h0000, 3'd0, 1'b0);
    gate = 1'b1;
    do_ticks(2);
    state_chk("gate_notrig", 16'h0000, 3'd0, 1'b0);

    // Attack ramp.
    atk = 8'h80; dec = 8'h40; sus = 16'h8000; rel = 8'hFF;
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    state_chk("attack_start", 16'h0000, 3'd1, 1'b1);
    do_ticks(511);
    state_chk("attack_511", 16'hFF80, 3'd1, 1'b1);
    do_tick();
    state_chk("attack_top", 16'hFFFF, 3'd2, 1'b1);

    // Decay to sustain, then live sustain tracking.
    do_ticks(511);
    state_chk("decay_511", 16'h803F, 3'd2, 1'b1);
    do_tick();
    state_chk("decay_sus", 16'h8000, 3'd3, 1'b1);
    sus = 16'h6000;
    do_tick();
    state_chk("sus_track", 16'h6000, 3'd3, 1'b1);
    sus = 16'h8000;
    do_tick();
    state_chk("sus_back", 16'h8000, 3'd3, 1'b1);

    // Release to idle.
    gate = 1'b0;
    cyc();
    state_chk("rel_start", 16'h8000, 3'd4, 1'b1);
    do_ticks(128);
    state_chk("rel_128", 16'h0080, 3'd4, 1'b1);
    do_tick();
    state_chk("rel_end", 16'h0000, 3'd0, 1'b0);

    // Instant attack and instant decay with zero steps.
    gate = 1'b1; trig = 1'b1; atk = 8'h00; dec = 8'h00;
    cyc();
    trig = 1'b0;
    do_tick();
    state_chk("atk_zero", 16'hFFFF, 3'd2, 1'b1);
    do_tick();
    state_chk("dec_zero", 16'h8000, 3'd3, 1'b1);

    // Release down to 0x4000, then retrigger on a tick cycle.
    rel = 8'h80; gate = 1'b0;
    cyc();
    do_ticks(128);
    state_chk("rel_half", 16'h4000, 3'd4, 1'b1);
    atk = 8'h80; gate = 1'b1; trig = 1'b1; tick = 1'b1;
    cyc();
    trig = 1'b0; tick = 1'b0;
    state_chk("retrig", 16'h4000, 3'd1, 1'b1);
    cyc(); cyc(); cyc();
    do_tick();
    state_chk("retrig_step", 16'h4080, 3'd1, 1'b1);

    // Gate falling on an attack tick wins over the tick.
    gate = 1'b0; tick = 1'b1;
    cyc();
    tick = 1'b0;
    state_chk("gate_fall_tick", 16'h4080, 3'd4, 1'b1);

    // Sustain above the decaying level jumps straight to sustain.
    gate = 1'b1; trig = 1'b1;
    cyc();
    trig = 1'b0;
    do_ticks(2);
    state_chk("atk_cont", 16'h4180, 3'd1, 1'b1);
    atk = 8'h00; dec = 8'h40;
    do_tick();
    chk("to_decay", {29'h0, stage}, 32'd2);
    do_tick();
    state_chk("dec_step", 16'hFFBF, 3'd2, 1'b1);

    // Async reset between clock edges, mid-decay.
    #1 rst = 1'b1;
    #1;
    state_chk("async_rst", 16'h0000, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_ticks(3);
    state_chk("post_rst_idle", 16'h0000, 3'd0, 1'b0);
    dec = 8'h40; sus = 16'hFFF0; atk = 8'h00;
    trig = 1'b1;
    cyc();
    trig = 1'b0;
    do_tick();
    do_tick();
    state_chk("dec_floor", 16'hFFF0, 3'd3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR envelope generator directly downstream of the touch-keyboard note decoder.
- Consumes the decoder's gate and trigger strobes and produces an unsigned amplitude envelope.
- The envelope advances once per audio sample tick; the voice mixer/VCA multiplies it with the oscillator output.
- Attack, decay and release rates and the sustain level are run-time inputs, driven from switches or a config register.

Parameters:
- ENV_WIDTH, 16, width of envelope value; full scale MAX = 2^ENV_WIDTH-1.
- RATE_WIDTH, 8, width of attack, decay and release step inputs; must be less than or equal to ENV_WIDTH.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-high.
- sample_tick_in  input  1  one-cycle strobe at audio sample rate; envelope value advances only on cycles where it is high.
- gate_in  input  1  key held (level).
- trigger_in  input  1  one-cycle note-on strobe.
- attack_step_in  input  RATE_WIDTH  amount added per tick in ATTACK.
- decay_step_in  input  RATE_WIDTH  amount subtracted per tick in DECAY.
- release_step_in  input  RATE_WIDTH  amount subtracted per tick in RELEASE.
- sustain_in  input  ENV_WIDTH  sustain level.
- env_out  output  ENV_WIDTH  current envelope value (registered).
- stage_out  output  3  current state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active_out  output  1  high whenever stage_out is not IDLE (registered).

Behaviour:
- Reset (asynchronous, while rst_in is high): env_out=0, stage_out=IDLE, active_out=0. Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.
- Step rule: steps are zero-extended to ENV_WIDTH. A step value of 0 means instant: the stage's target is reached on the first tick.
- Arithmetic is done at ENV_WIDTH+1 bits; no wrap-around is permitted in either direction.
- Event priority each clock, evaluated every clock, not only on ticks:
  1. trigger_in && gate_in → next state ATTACK; env_out held this cycle. Applies from any state (retrigger without reset to 0, so no click).
  2. Otherwise, !gate_in while in ATTACK, DECAY or SUSTAIN → next state RELEASE; env_out held this cycle.
  3. Otherwise, if sample_tick_in is high, apply the per-state update below.
- trigger_in with gate_in low is ignored.
- gate_in high without a trigger while in IDLE or RELEASE does not start a note.
- IDLE: env_out=0.
- ATTACK tick: if env+step ≥ MAX → env=MAX, go to DECAY; otherwise env += step.
- DECAY tick: if env−step ≤ sustain_in (signed compare at ENV_WIDTH+1 bits) → env=sustain_in, go to SUSTAIN; otherwise env −= step. If sustain_in is above env, the result is env=sustain_in.
- SUSTAIN tick: env=sustain_in, so a live sustain change is tracked on the next tick.
- RELEASE tick: if env ≤ step → env=0, go to IDLE; otherwise env −= step.
- Latency:
  - State and env changes appear on the clock edge following the qualifying cycle.
  - active_out changes on the same edge as stage_out.
  - No combinational path from any input to any output.
- Inputs are synchronous to clk_in. Rate and sustain inputs are sampled on the tick in which they are used.

Test Plan:
ENV_WIDTH=16, RATE_WIDTH=8, tick every 4 clocks.
- Attack ramp: gate=1 plus trigger pulse, attack_step=0x80 → stage=1 next clock. After 511 ticks env=0xFF80. Tick 512: env=0xFFFF, stage=2.
- Decay to sustain: decay_step=0x40, sustain=0x8000, starting from env 0xFFFF → after 511 ticks env=0x803F. Tick 512: env=0x8000, stage=3. Sustain then changed to 0x6000 → env=0x6000 on next tick.
- Release: sustain at env 0x8000, release_step=0xFF, gate dropped → stage=4 next clock with env unchanged. After 128 ticks env=0x0080. Tick 129: env=0, stage=0, active_out=0.
- Retrigger: during release at env 0x4000, trigger+gate on a tick cycle → stage=1, env stays 0x4000 that edge. Next tick env=0x4080.
- Edge cases:
  - attack_step=0 → first tick env=0xFFFF, stage=2.
  - trigger with gate=0 in IDLE → stays stage 0, env 0.
  - gate fall coincident with an ATTACK tick → stage=4, env unchanged.
- Async reset: assert rst_in mid-decay between clock edges → env_out=0, stage=0, active_out=0 before the next edge. After release, the block idles until a trigger arrives.
